// File: rtl/usb_reg_arb_if.sv
// rtl/usb_reg_arb_if.sv - requester and register bus signals of the two-master register arbiter
interface usb_reg_arb_if #(
  parameter int AW = 9,
  parameter int DW = 32
) ();
  logic            m0_req,   m1_req;
  logic            m0_wr,    m1_wr;
  logic [AW-1:0]   m0_addr,  m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_be,    m1_be;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            m0_ack,   m1_ack;
  logic            m0_err,   m1_err;
  logic            reg_cs;
  logic            reg_wr;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [DW/8-1:0] reg_be;
  logic [DW-1:0]   reg_rdata;
  logic            reg_ack;
  logic            arb_busy;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
    input  m0_wdata, m1_wdata, m0_be, m1_be,
    output m0_rdata, m1_rdata, m0_ack, m1_ack, m0_err, m1_err,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack,
    output arb_busy
  );

  // Requesters plus register slave
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
    output m0_wdata, m1_wdata, m0_be, m1_be,
    input  m0_rdata, m1_rdata, m0_ack, m1_ack, m0_err, m1_err,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack,
    input  arb_busy
  );
endinterface

// File: rtl/usb_reg_arb.sv
// rtl/usb_reg_arb.sv - round-robin arbiter sharing one register bus between two requesters
module usb_reg_arb #(
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic         app_clk,
  input  logic         reset,
  usb_reg_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t          state, state_nxt;
  logic            ptr;
  logic            gnt;
  logic            just_resp;
  logic            err_q;
  logic [7:0]      cnt;
  logic            lat_wr;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [DW/8-1:0] lat_be;
  logic [DW-1:0]   rdata0, rdata1;

  logic elig0, elig1, win, do_grant, tmo_hit;

  // The requester just acked sits out one IDLE cycle so its still-held req is not re-served.
  always_comb begin
    elig0    = bus.m0_req && !(just_resp && !gnt);
    elig1    = bus.m1_req && !(just_resp &&  gnt);
    win      = (elig0 && elig1) ? ptr : elig1;
    do_grant = (state == IDLE) && (elig0 || elig1);
    tmo_hit  = (cnt == TMO_LAST);
  end

  always_ff @(posedge app_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_grant) state_nxt = BUSY;
      BUSY:    if (bus.reg_ack || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge app_clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      just_resp <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= 8'd0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      just_resp <= (state == RESP);
      case (state)
        IDLE: begin
          if (do_grant) begin
            gnt       <= win;
            ptr       <= ~win;
            cnt       <= 8'd0;
            lat_wr    <= win ? bus.m1_wr    : bus.m0_wr;
            lat_addr  <= win ? bus.m1_addr  : bus.m0_addr;
            lat_wdata <= win ? bus.m1_wdata : bus.m0_wdata;
            lat_be    <= win ? bus.m1_be    : bus.m0_be;
          end
        end
        BUSY: begin
          // An ack landing on the timeout cycle still counts as a normal completion.
          if (bus.reg_ack) begin
            err_q <= 1'b0;
            if (gnt) rdata1 <= bus.reg_rdata;
            else     rdata0 <= bus.reg_rdata;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            if (gnt) rdata1 <= '1;
            else     rdata0 <= '1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reg_cs    = (state == BUSY);
  assign bus.reg_wr    = lat_wr;
  assign bus.reg_addr  = lat_addr;
  assign bus.reg_wdata = lat_wdata;
  assign bus.reg_be    = lat_be;
  assign bus.arb_busy  = (state != IDLE);
  assign bus.m0_ack    = (state == RESP) && !gnt;
  assign bus.m1_ack    = (state == RESP) &&  gnt;
  assign bus.m0_err    = bus.m0_ack && err_q;
  assign bus.m1_err    = bus.m1_ack && err_q;
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;

endmodule

// File: tb/tb_usb_reg_arb.sv
// tb/tb_usb_reg_arb.sv - directed-vector bench for usb_reg_arb
module tb_usb_reg_arb;

  logic app_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  usb_reg_arb_if #(.AW(9), .DW(32)) bus ();

  usb_reg_arb #(.AW(9), .DW(32), .TMO_CYC(4)) dut (
    .app_clk (app_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 app_clk = ~app_clk;

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.m0_req = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (bus.arb_busy !== 1'b0 || bus.reg_cs !== 1'b0 || bus.reg_wr !== 1'b0) begin
      n_err++; $display("FAIL rst_ctl: busy=%b cs=%b wr=%b expected 0 0 0", bus.arb_busy, bus.reg_cs, bus.reg_wr); end
    n_vec++; if (bus.reg_addr !== 9'h0 || bus.reg_wdata !== 32'h0 || bus.reg_be !== 4'h0) begin
      n_err++; $display("FAIL rst_bus: addr=%h wdata=%h be=%h expected 0", bus.reg_addr, bus.reg_wdata, bus.reg_be); end
    n_vec++; if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.m0_err !== 1'b0 || bus.m1_err !== 1'b0) begin
      n_err++; $display("FAIL rst_ack: ack=%b%b err=%b%b expected 0", bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err); end
    n_vec++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
      n_err++; $display("FAIL rst_rdata: m0=%h m1=%h expected 0", bus.m0_rdata, bus.m1_rdata); end
    bus.m0_req = 1'b0;
    reset = 1'b0;
    tick();
    n_vec++; if (bus.arb_busy !== 1'b0) begin
      n_err++; $display("FAIL rst_release_busy: got %b expected 0", bus.arb_busy); end
  endtask

  task automatic test_read();
    int cs_cnt = 0;
    bus.m0_wr = 1'b0; bus.m0_addr = 9'h040; bus.m0_be = 4'hF; bus.m0_req = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (bus.reg_cs === 1'b1) cs_cnt++;
      n_vec++; if (bus.reg_addr !== 9'h040 || bus.reg_wr !== 1'b0 || bus.m0_ack !== 1'b0) begin
        n_err++; $display("FAIL rd_busy c%0d: addr=%h wr=%b ack=%b expected 040 0 0", c, bus.reg_addr, bus.reg_wr, bus.m0_ack); end
      if (c == 3) begin bus.reg_ack = 1'b1; bus.reg_rdata = 32'h1234_5678; end
      tick();
    end
    bus.reg_ack = 1'b0;
    n_vec++; if (cs_cnt != 3) begin
      n_err++; $display("FAIL rd_cs_len: got %0d expected 3", cs_cnt); end
    n_vec++; if (bus.m0_ack !== 1'b1 || bus.m0_err !== 1'b0 || bus.reg_cs !== 1'b0 || bus.m1_ack !== 1'b0) begin
      n_err++; $display("FAIL rd_ack: ack=%b err=%b cs=%b m1_ack=%b expected 1 0 0 0", bus.m0_ack, bus.m0_err, bus.reg_cs, bus.m1_ack); end
    n_vec++; if (bus.m0_rdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL rd_rdata: got %h expected 12345678", bus.m0_rdata); end
    bus.m0_req = 1'b0;
    tick();
    n_vec++; if (bus.m0_ack !== 1'b0) begin
      n_err++; $display("FAIL rd_ack_pulse: got %b expected 0", bus.m0_ack); end
    tick();
  endtask

  task automatic test_write();
    bus.m1_wr = 1'b1; bus.m1_addr = 9'h088; bus.m1_wdata = 32'h0A5A_5A5A; bus.m1_be = 4'b0011; bus.m1_req = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      n_vec++; if (bus.reg_cs !== 1'b1 || bus.reg_wr !== 1'b1 || bus.reg_addr !== 9'h088 ||
                   bus.reg_be !== 4'b0011 || bus.reg_wdata !== 32'h0A5A_5A5A) begin
        n_err++; $display("FAIL wr_hold c%0d: cs=%b wr=%b addr=%h be=%b wdata=%h expected 1 1 088 0011 0a5a5a5a",
                          c, bus.reg_cs, bus.reg_wr, bus.reg_addr, bus.reg_be, bus.reg_wdata); end
      bus.m1_wr = 1'b0; bus.m1_addr = 9'h1FF; bus.m1_wdata = 32'h0; bus.m1_be = 4'hF;
      if (c == 3) begin bus.reg_ack = 1'b1; bus.reg_rdata = 32'hDEAD_0001; end
      tick();
    end
    bus.reg_ack = 1'b0;
    n_vec++; if (bus.m1_ack !== 1'b1 || bus.m1_err !== 1'b0 || bus.m0_ack !== 1'b0) begin
      n_err++; $display("FAIL wr_ack: m1_ack=%b m1_err=%b m0_ack=%b expected 1 0 0", bus.m1_ack, bus.m1_err, bus.m0_ack); end
    n_vec++; if (bus.m1_rdata !== 32'hDEAD_0001 || bus.m0_rdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL wr_rdata: m1=%h m0=%h expected dead0001 12345678", bus.m1_rdata, bus.m0_rdata); end
    bus.m1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic exp0, exp1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.m0_wr = 1'b0; bus.m0_addr = 9'h004; bus.m1_wr = 1'b0; bus.m1_addr = 9'h008;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    bus.reg_ack = 1'b1; bus.reg_rdata = 32'h0000_0055;
    for (int t = 1; t <= 11; t++) begin
      tick();
      exp0 = (t == 2) || (t == 8);
      exp1 = (t == 5) || (t == 11);
      n_vec++; if (bus.m0_ack !== exp0 || bus.m1_ack !== exp1) begin
        n_err++; $display("FAIL rr_order t%0d: ack m0=%b m1=%b expected %b %b", t, bus.m0_ack, bus.m1_ack, exp0, exp1); end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.reg_ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int  cs_cnt = 0;
    logic got = 1'b0;
    bus.m0_wr = 1'b0; bus.m0_addr = 9'h010; bus.m0_req = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.m0_ack === 1'b1) got = 1'b1;
      else if (bus.reg_cs === 1'b1) cs_cnt++;
    end
    n_vec++; if (got !== 1'b1) begin
      n_err++; $display("FAIL tmo_ack_seen: got %b expected 1 within 20 cycles", got); end
    n_vec++; if (cs_cnt != 4) begin
      n_err++; $display("FAIL tmo_cs_len: got %0d expected 4", cs_cnt); end
    n_vec++; if (bus.m0_err !== 1'b1 || bus.m0_rdata !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL tmo_resp: err=%b rdata=%h expected 1 ffffffff", bus.m0_err, bus.m0_rdata); end
    bus.m0_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ack_at_timeout();
    bus.m1_wr = 1'b0; bus.m1_addr = 9'h0C0; bus.m1_req = 1'b1;
    tick(); tick(); tick(); tick();
    n_vec++; if (bus.reg_cs !== 1'b1) begin
      n_err++; $display("FAIL tie_cs: got %b expected 1 in fourth busy cycle", bus.reg_cs); end
    bus.reg_ack = 1'b1; bus.reg_rdata = 32'hCAFE_F00D;
    tick();
    bus.reg_ack = 1'b0;
    n_vec++; if (bus.m1_ack !== 1'b1 || bus.m1_err !== 1'b0 || bus.m1_rdata !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL tie_resp: ack=%b err=%b rdata=%h expected 1 0 cafef00d", bus.m1_ack, bus.m1_err, bus.m1_rdata); end
    bus.m1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bus.m0_wr = 1'b0; bus.m0_addr = 9'h020; bus.m0_req = 1'b1;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.reg_cs !== 1'b0 || bus.arb_busy !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_abort: cs=%b busy=%b expected 0 0", bus.reg_cs, bus.arb_busy); end
    bus.m0_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_vec++; if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.m0_rdata !== 32'h0) begin
        n_err++; $display("FAIL mid_rst_noack t%0d: ack=%b%b m0_rdata=%h expected 00 0", t, bus.m0_ack, bus.m1_ack, bus.m0_rdata); end
    end
    bus.m1_wr = 1'b0; bus.m1_addr = 9'h100; bus.m1_req = 1'b1;
    tick();
    n_vec++; if (bus.reg_cs !== 1'b1 || bus.reg_addr !== 9'h100) begin
      n_err++; $display("FAIL mid_rst_new_cs: cs=%b addr=%h expected 1 100", bus.reg_cs, bus.reg_addr); end
    bus.reg_ack = 1'b1; bus.reg_rdata = 32'h0BAD_BEEF;
    tick();
    bus.reg_ack = 1'b0;
    n_vec++; if (bus.m1_ack !== 1'b1 || bus.m1_err !== 1'b0 || bus.m1_rdata !== 32'h0BAD_BEEF) begin
      n_err++; $display("FAIL mid_rst_new_resp: ack=%b err=%b rdata=%h expected 1 0 0badbeef", bus.m1_ack, bus.m1_err, bus.m1_rdata); end
    bus.m1_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
    bus.reg_ack = 1'b0; bus.reg_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
